// File: rtl/rob_ctrl_pkg.sv
// Shared types and sizing for the reorder-buffer controller.
package rob_ctrl_pkg;

    localparam int ROB_DEPTH   = 16;
    localparam int ROB_IDX_LEN = $clog2(ROB_DEPTH);

    typedef enum logic [1:0] {
        FREE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } rob_state_t;

    typedef enum logic {
        RUN   = 1'b0,
        EXCPT = 1'b1
    } rob_fsm_t;

endpackage

// File: rtl/rob_ctrl_if.sv
// Issue/completion/commit handshake bundle between the pipeline (master) and the ROB controller (slave).
interface rob_ctrl_if #(
    parameter int IDX_LEN = 4
);

    logic               alloc_valid_i;
    logic               alloc_ready_o;
    logic [IDX_LEN-1:0] alloc_idx_o;
    logic               cdb_valid_i;
    logic [IDX_LEN-1:0] cdb_idx_i;
    logic               cdb_except_i;
    logic               commit_valid_o;
    logic               commit_ready_i;
    logic [IDX_LEN-1:0] commit_idx_o;

    modport master (
        output alloc_valid_i, cdb_valid_i, cdb_idx_i, cdb_except_i, commit_ready_i,
        input  alloc_ready_o, alloc_idx_o, commit_valid_o, commit_idx_o
    );

    modport slave (
        input  alloc_valid_i, cdb_valid_i, cdb_idx_i, cdb_except_i, commit_ready_i,
        output alloc_ready_o, alloc_idx_o, commit_valid_o, commit_idx_o
    );

endinterface

// File: rtl/rob_ptr.sv
// Circular-buffer pointer with a wrap bit above the index; clear has priority over increment.
module rob_ptr #(
    parameter int IDX_LEN = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [IDX_LEN:0] ptr_o
);

    logic [IDX_LEN:0] r_ptr;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ptr <= '0;
        end else if (clr_i) begin
            r_ptr <= '0;
        end else if (inc_i) begin
            r_ptr <= r_ptr + {{IDX_LEN{1'b0}}, 1'b1};
        end
    end

    assign ptr_o = r_ptr;

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer allocation/completion/commit controller with precise-exception flush sequencing.
// Optional feature: define ROB_PERF_CNT_EN to add the saturating allocation-stall counter stall_cnt_o.
module rob_ctrl
    import rob_ctrl_pkg::*;
#(
    parameter int DEPTH   = ROB_DEPTH,
    parameter int IDX_LEN = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               flush_i,
    rob_ctrl_if.slave          rob_if,
    output logic               except_o,
    output logic [IDX_LEN-1:0] except_idx_o,
    output logic               flush_o,
    output logic               empty_o,
    output logic [IDX_LEN:0]   count_o
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt_o
`endif
);

    rob_fsm_t           r_state;
    rob_fsm_t           w_state_nxt;
    rob_state_t         r_entry [DEPTH];
    logic [DEPTH-1:0]   r_except;

    logic [IDX_LEN:0]   w_head_ptr;
    logic [IDX_LEN:0]   w_tail_ptr;
    logic [IDX_LEN-1:0] w_head_idx;
    logic [IDX_LEN-1:0] w_tail_idx;
    logic               w_empty;
    logic               w_full;
    logic               w_head_done;
    logic               w_alloc_ready;
    logic               w_commit_valid;
    logic               w_alloc_fire;
    logic               w_commit_fire;
    logic               w_clr;
    logic               w_except;

    assign w_head_idx = w_head_ptr[IDX_LEN-1:0];
    assign w_tail_idx = w_tail_ptr[IDX_LEN-1:0];
    assign w_empty    = (w_head_ptr == w_tail_ptr);
    assign w_full     = (w_head_idx == w_tail_idx) && (w_head_ptr[IDX_LEN] != w_tail_ptr[IDX_LEN]);

    // Ready/valid come from registers only, so a full ROB stays closed even while the head commits.
    assign w_head_done    = !w_empty && (r_entry[w_head_idx] == DONE);
    assign w_alloc_ready  = (r_state == RUN) && !w_full;
    assign w_commit_valid = (r_state == RUN) && w_head_done && !r_except[w_head_idx];
    assign w_alloc_fire   = rob_if.alloc_valid_i && w_alloc_ready;
    assign w_commit_fire  = w_commit_valid && rob_if.commit_ready_i;

    rob_ptr #(.IDX_LEN(IDX_LEN)) u_head_ptr (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (w_commit_fire),
        .clr_i   (w_clr),
        .ptr_o   (w_head_ptr)
    );

    rob_ptr #(.IDX_LEN(IDX_LEN)) u_tail_ptr (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (w_alloc_fire),
        .clr_i   (w_clr),
        .ptr_o   (w_tail_ptr)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An external flush in RUN pre-empts a faulting head; EXCPT always lasts exactly one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_except    = 1'b0;
        case (r_state)
            RUN: begin
                if (flush_i) begin
                    w_clr = 1'b1;
                end else if (w_head_done && r_except[w_head_idx]) begin
                    w_state_nxt = EXCPT;
                end
            end
            EXCPT: begin
                w_clr       = 1'b1;
                w_except    = 1'b1;
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // Alloc, completion and commit never target the same entry in one cycle, so their order here is free.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= FREE;
            end
            r_except <= '0;
        end else if (w_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= FREE;
            end
            r_except <= '0;
        end else begin
            if (rob_if.cdb_valid_i && (r_entry[rob_if.cdb_idx_i] == PEND)) begin
                r_entry[rob_if.cdb_idx_i]  <= DONE;
                r_except[rob_if.cdb_idx_i] <= rob_if.cdb_except_i;
            end
            if (w_commit_fire) begin
                r_entry[w_head_idx] <= FREE;
            end
            if (w_alloc_fire) begin
                r_entry[w_tail_idx]  <= PEND;
                r_except[w_tail_idx] <= 1'b0;
            end
        end
    end

    assign rob_if.alloc_ready_o  = w_alloc_ready;
    assign rob_if.alloc_idx_o    = w_tail_idx;
    assign rob_if.commit_valid_o = w_commit_valid;
    assign rob_if.commit_idx_o   = w_head_idx;
    assign except_o              = w_except;
    assign except_idx_o          = w_head_idx;
    assign flush_o               = w_except;
    assign empty_o               = w_empty;
    assign count_o               = w_tail_ptr - w_head_ptr;

`ifdef ROB_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stall_cnt <= '0;
        end else if (rob_if.alloc_valid_i && !w_alloc_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

    cdb_to_pending_entry: assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        (rob_if.cdb_valid_i && (r_state == RUN) && !flush_i) |-> (r_entry[rob_if.cdb_idx_i] == PEND)
    ) else $error("rob_ctrl: completion broadcast to an entry that is not pending");

endmodule

// File: tb/tb_rob_ctrl.sv
// Testbench for rob_ctrl: directed scenarios plus random traffic checked against an in-order queue model.
module tb_rob_ctrl;
   import rob_ctrl_pkg::*;

   localparam int IDX = ROB_IDX_LEN;
   localparam int D   = ROB_DEPTH;

   logic clock = 1'b0;
   logic rstN  = 1'b0;
   logic flush = 1'b0;

   logic           exceptOut;
   logic [IDX-1:0] exceptIdx;
   logic           flushOut;
   logic           emptyOut;
   logic [IDX:0]   countOut;
`ifdef ROB_PERF_CNT_EN
   logic [31:0]    stallCnt;
`endif

   int checkCount = 0;
   int errorCount = 0;

   // Model: the occupied tags in program order, plus completion/exception flags per tag.
   int          robQ[$];
   bit          mDone [D];
   bit          mExc [D];
   int          nextTag = 0;
   bit          inExcpt = 1'b0;
   int unsigned mStall  = 0;

   // Clock generation
   always #5 clock = ~clock;

   rob_ctrl_if #(.IDX_LEN(IDX)) rif ();

   rob_ctrl u_dut (
      .clk_i        (clock),
      .rst_n_i      (rstN),
      .flush_i      (flush),
      .rob_if       (rif.slave),
      .except_o     (exceptOut),
      .except_idx_o (exceptIdx),
      .flush_o      (flushOut),
      .empty_o      (emptyOut),
      .count_o      (countOut)
`ifdef ROB_PERF_CNT_EN
      ,
      .stall_cnt_o  (stallCnt)
`endif
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit isPending(input int t);
      foreach (robQ[i]) begin
         if (robQ[i] == t) return !mDone[t];
      end
      return 1'b0;
   endfunction

   function automatic bit expReady();
      return !inExcpt && (robQ.size() < D);
   endfunction

   function automatic bit expCommitValid();
      return !inExcpt && (robQ.size() > 0) && mDone[robQ[0]] && !mExc[robQ[0]];
   endfunction

   function automatic int expHead();
      return (robQ.size() > 0) ? robQ[0] : nextTag;
   endfunction

   // Compare every DUT output against the model for the current cycle
   task automatic checkAll();
      checkOutput("alloc_ready", rif.alloc_ready_o, expReady());
      checkOutput("alloc_idx", rif.alloc_idx_o, nextTag);
      checkOutput("commit_valid", rif.commit_valid_o, expCommitValid());
      checkOutput("commit_idx", rif.commit_idx_o, expHead());
      checkOutput("except_o", exceptOut, inExcpt);
      checkOutput("flush_o", flushOut, inExcpt);
      if (inExcpt) checkOutput("except_idx", exceptIdx, robQ[0]);
      checkOutput("empty_o", emptyOut, robQ.size() == 0);
      checkOutput("count_o", countOut, robQ.size());
`ifdef ROB_PERF_CNT_EN
      checkOutput("stall_cnt", stallCnt, mStall);
`endif
   endtask

   // Advance the model across one rising edge using the inputs of this cycle
   task automatic modelStep(input bit av, input bit cv, input int ci, input bit ce, input bit cr, input bit fl);
      bit aFire;
      bit cFire;
      bit goEx;
      aFire = av && expReady();
      cFire = cr && expCommitValid();
      if (av && !expReady() && mStall != 32'hFFFF_FFFF) mStall++;
      if (inExcpt || fl) begin
         robQ.delete();
         nextTag = 0;
         inExcpt = 1'b0;
         return;
      end
      goEx = (robQ.size() > 0) && mDone[robQ[0]] && mExc[robQ[0]];
      if (cv && isPending(ci)) begin
         mDone[ci] = 1'b1;
         mExc[ci]  = ce;
      end
      if (cFire) void'(robQ.pop_front());
      if (aFire) begin
         robQ.push_back(nextTag);
         mDone[nextTag] = 1'b0;
         mExc[nextTag]  = 1'b0;
         nextTag = (nextTag + 1) % D;
      end
      inExcpt = goEx;
   endtask

   // One cycle: drive at the falling edge, check just after, then update the model
   task automatic applyStimulus(input bit av, input bit cv, input int ci, input bit ce, input bit cr, input bit fl);
      @(negedge clock);
      rif.alloc_valid_i  = av;
      rif.cdb_valid_i    = cv;
      rif.cdb_idx_i      = ci[IDX-1:0];
      rif.cdb_except_i   = ce;
      rif.commit_ready_i = cr;
      flush              = fl;
      #1;
      checkAll();
      modelStep(av, cv, ci, ce, cr, fl);
   endtask

   // Asynchronous reset in the middle of a cycle; outputs must clear without a clock edge
   task automatic doReset();
      @(negedge clock);
      #2;
      rstN               = 1'b0;
      rif.alloc_valid_i  = 1'b0;
      rif.cdb_valid_i    = 1'b0;
      rif.cdb_idx_i      = '0;
      rif.cdb_except_i   = 1'b0;
      rif.commit_ready_i = 1'b0;
      flush              = 1'b0;
      #1;
      checkOutput("rst_alloc_ready", rif.alloc_ready_o, 1);
      checkOutput("rst_alloc_idx", rif.alloc_idx_o, 0);
      checkOutput("rst_commit_valid", rif.commit_valid_o, 0);
      checkOutput("rst_commit_idx", rif.commit_idx_o, 0);
      checkOutput("rst_except", exceptOut, 0);
      checkOutput("rst_except_idx", exceptIdx, 0);
      checkOutput("rst_flush_o", flushOut, 0);
      checkOutput("rst_empty", emptyOut, 1);
      checkOutput("rst_count", countOut, 0);
`ifdef ROB_PERF_CNT_EN
      checkOutput("rst_stall", stallCnt, 0);
`endif
      robQ.delete();
      nextTag = 0;
      inExcpt = 1'b0;
      mStall  = 0;
      @(negedge clock);
      rstN = 1'b1;
   endtask

   // Random traffic; completions only target pending entries
   task automatic randomCycle();
      int pl[$];
      bit av, cv, ce, cr, fl;
      int ci;
      av = ($urandom_range(99) < 70);
      cr = ($urandom_range(99) < 70);
      fl = ($urandom_range(99) < 3);
      cv = 1'b0;
      ci = 0;
      ce = 1'b0;
      foreach (robQ[i]) if (!mDone[robQ[i]]) pl.push_back(robQ[i]);
      if (!inExcpt && pl.size() > 0 && $urandom_range(99) < 60) begin
         cv = 1'b1;
         ci = pl[$urandom_range(pl.size() - 1)];
         ce = ($urandom_range(99) < 8);
      end
      applyStimulus(av, cv, ci, ce, cr, fl);
   endtask

   initial begin
      int lastTag;
      rif.alloc_valid_i  = 1'b0;
      rif.cdb_valid_i    = 1'b0;
      rif.cdb_idx_i      = '0;
      rif.cdb_except_i   = 1'b0;
      rif.commit_ready_i = 1'b0;
      doReset();

      // Fill: 17 requests, tags 0..15 then stall
      for (int k = 0; k < 17; k++) begin
         applyStimulus(1, 0, 0, 0, 0, 0);
         if (k < 16) checkOutput("fill_tag", rif.alloc_idx_o, k);
      end
      checkOutput("fill_ready", rif.alloc_ready_o, 0);
      checkOutput("fill_count", countOut, 16);
      checkOutput("fill_empty", emptyOut, 0);
      applyStimulus(0, 0, 0, 0, 0, 1);

      // Out-of-order completion, in-order commit
      for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 2, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("ooo_not_yet", rif.commit_valid_o, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("ooo_valid0", rif.commit_valid_o, 1);
      checkOutput("ooo_idx0", rif.commit_idx_o, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("ooo_stall1", rif.commit_valid_o, 0);
      checkOutput("ooo_idx1", rif.commit_idx_o, 1);
      applyStimulus(0, 1, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("ooo_valid1", rif.commit_valid_o, 1);
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("ooo_idx2", rif.commit_idx_o, 2);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("ooo_drained", emptyOut, 1);

      // Exception at head
      applyStimulus(0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("exc_pre_pulse", exceptOut, 0);
      checkOutput("exc_no_commit", rif.commit_valid_o, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("exc_pulse", exceptOut, 1);
      checkOutput("exc_flush_o", flushOut, 1);
      checkOutput("exc_idx", exceptIdx, 0);
      checkOutput("exc_commit_valid", rif.commit_valid_o, 0);
      checkOutput("exc_alloc_ready", rif.alloc_ready_o, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("exc_after_empty", emptyOut, 1);
      checkOutput("exc_after_tag", rif.alloc_idx_o, 0);
      checkOutput("exc_after_pulse", exceptOut, 0);

      // External flush with a simultaneous allocation
      for (int k = 0; k < 5; k++) applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("xfl_count", countOut, 0);
      checkOutput("xfl_empty", emptyOut, 1);
      checkOutput("xfl_tag", rif.alloc_idx_o, 0);
      checkOutput("xfl_flush_o", flushOut, 0);

      // Steady state at 15 entries, wrapping the tags
      for (int k = 0; k < 15; k++) begin
         lastTag = (nextTag + D - 1) % D;
         applyStimulus(1, isPending(lastTag), lastTag, 0, 0, 0);
      end
      for (int k = 0; k < 40; k++) begin
         lastTag = (nextTag + D - 1) % D;
         applyStimulus(1, isPending(lastTag), lastTag, 0, 1, 0);
         checkOutput("steady_count", countOut, 15);
         checkOutput("steady_ready", rif.alloc_ready_o, 1);
      end

`ifdef ROB_PERF_CNT_EN
      // Stall counter: fill after reset, then 10 refused requests; survives a flush
      doReset();
      for (int k = 0; k < 26; k++) applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("stall_ten", stallCnt, 10);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("stall_kept", stallCnt, 10);
`endif

      // Random traffic with a reset in the middle
      for (int k = 0; k < 400; k++) randomCycle();
      doReset();
      for (int k = 0; k < 400; k++) randomCycle();

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
